// File: rtl/npu_tile_sequencer.sv
// Tile scheduler: walks an IMG_W x IMG_H 8-bit image in TILE x TILE blocks,
// fetching each tile into the NPU input bus and writing the NPU result back.
module npu_tile_sequencer #(
  parameter int IMG_W   = 400,
  parameter int IMG_H   = 400,
  parameter int TILE    = 10,
  parameter int ADDR_W  = 19,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_pulse,
  input  logic                     step_pulse,
  input  logic                     abort,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [7:0]               rd_data,
  output logic [TILE*TILE*16-1:0]  npu_in,
  output logic                     npu_start,
  input  logic                     npu_done,
  input  logic [TILE*TILE*8-1:0]   npu_out,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [7:0]               wr_data,
  output logic                     wr_en,
  output logic                     busy,
  output logic                     paused,
  output logic                     done,
  output logic [7:0]               tile_x,
  output logic [7:0]               tile_y
);

  localparam int NPOS  = TILE * TILE;
  localparam int NX    = (IMG_W + TILE - 1) / TILE;
  localparam int NY    = (IMG_H + TILE - 1) / TILE;
  localparam int IDX_W = $clog2(NPOS);
  localparam int C_W   = $clog2(TILE);
  localparam int CRD_W = ADDR_W + 2;

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(NPOS - 1);
  localparam logic [C_W-1:0]   LAST_C   = C_W'(TILE - 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, DRAIN, RUN, WAIT_NPU, WRITE, ADVANCE, PAUSE, FINISH
  } state_t;

  state_t             state_q, state_d;
  logic               mode_cont_q, mode_cont_d;
  logic [7:0]         tile_x_q, tile_x_d, tile_y_q, tile_y_d;
  logic [CRD_W-1:0]   col0_q, col0_d, row0_q, row0_d;
  logic [ADDR_W-1:0]  rowbase_q, rowbase_d;
  logic [C_W-1:0]     cur_c_q, cur_c_d;
  logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
  logic [CRD_W-1:0]   cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [ADDR_W-1:0]  cur_rowaddr_q, cur_rowaddr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [7:0]         wr_data_q, wr_data_d;
  logic               wr_en_q, wr_en_d;
  logic               tag_vld_q [MEM_LAT+1];
  logic               tag_vld_d [MEM_LAT+1];
  logic [IDX_W-1:0]   tag_idx_q [MEM_LAT+1];
  logic [IDX_W-1:0]   tag_idx_d [MEM_LAT+1];
  logic [7:0]         pix_q [NPOS];
  logic [7:0]         pix_d [NPOS];

  logic               load_cur, step_cur, abort_hit, pending, in_img;
  logic [ADDR_W-1:0]  pos_addr;

  always_comb begin
    abort_hit = abort && (state_q != IDLE);
    pending   = 1'b0;
    for (int k = 0; k < MEM_LAT; k++) pending = pending | tag_vld_q[k];

    state_d       = state_q;
    mode_cont_d   = mode_cont_q;
    tile_x_d      = tile_x_q;
    tile_y_d      = tile_y_q;
    col0_d        = col0_q;
    row0_d        = row0_q;
    rowbase_d     = rowbase_q;
    cur_c_d       = cur_c_q;
    cur_idx_d     = cur_idx_q;
    cur_row_d     = cur_row_q;
    cur_col_d     = cur_col_q;
    cur_rowaddr_d = cur_rowaddr_q;
    load_cur      = 1'b0;
    step_cur      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_pulse || step_pulse) begin
          mode_cont_d = start_pulse;
          tile_x_d    = '0;
          tile_y_d    = '0;
          col0_d      = '0;
          row0_d      = '0;
          rowbase_d   = '0;
          state_d     = FETCH;
          load_cur    = 1'b1;
        end
      end
      FETCH: begin
        if (cur_idx_q == LAST_POS) state_d = DRAIN;
        else                       step_cur = 1'b1;
      end
      DRAIN: begin
        // The oldest tag stage is consumed this cycle, so only younger ones hold us here.
        if (!pending) state_d = RUN;
      end
      RUN: state_d = WAIT_NPU;
      WAIT_NPU: begin
        if (npu_done) begin
          state_d  = WRITE;
          load_cur = 1'b1;
        end
      end
      WRITE: begin
        if (cur_idx_q == LAST_POS) state_d = ADVANCE;
        else                       step_cur = 1'b1;
      end
      ADVANCE: begin
        if (tile_x_q == 8'(NX - 1) && tile_y_q == 8'(NY - 1)) begin
          state_d = FINISH;
        end else begin
          if (tile_x_q == 8'(NX - 1)) begin
            tile_x_d  = '0;
            col0_d    = '0;
            tile_y_d  = tile_y_q + 8'd1;
            row0_d    = row0_q + CRD_W'(TILE);
            rowbase_d = rowbase_q + ADDR_W'(TILE * IMG_W);
          end else begin
            tile_x_d = tile_x_q + 8'd1;
            col0_d   = col0_q + CRD_W'(TILE);
          end
          if (mode_cont_q) begin
            state_d  = FETCH;
            load_cur = 1'b1;
          end else begin
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (start_pulse || step_pulse) begin
          if (start_pulse) mode_cont_d = 1'b1;
          state_d  = FETCH;
          load_cur = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort_hit) begin
      state_d  = IDLE;
      load_cur = 1'b0;
      step_cur = 1'b0;
    end

    // Cursor walks the tile row-major; row start address advances by IMG_W per row.
    if (load_cur) begin
      cur_c_d       = '0;
      cur_idx_d     = '0;
      cur_row_d     = row0_d;
      cur_col_d     = col0_d;
      cur_rowaddr_d = rowbase_d + ADDR_W'(col0_d);
    end else if (step_cur) begin
      cur_idx_d = cur_idx_q + 1'b1;
      if (cur_c_q == LAST_C) begin
        cur_c_d       = '0;
        cur_row_d     = cur_row_q + 1'b1;
        cur_col_d     = col0_q;
        cur_rowaddr_d = cur_rowaddr_q + ADDR_W'(IMG_W);
      end else begin
        cur_c_d   = cur_c_q + 1'b1;
        cur_col_d = cur_col_q + 1'b1;
      end
    end

    in_img   = (cur_col_d < CRD_W'(IMG_W)) && (cur_row_d < CRD_W'(IMG_H));
    pos_addr = cur_rowaddr_d + ADDR_W'(cur_c_d);

    rd_addr_d = (state_d == FETCH) ? pos_addr : rd_addr_q;
    wr_en_d   = (state_d == WRITE) && in_img;
    wr_addr_d = (state_d == WRITE) ? pos_addr : wr_addr_q;
    wr_data_d = (state_d == WRITE) ? npu_out[{cur_idx_d, 3'b000} +: 8] : wr_data_q;

    // Stage 0 travels with rd_addr; stage MEM_LAT lines up with rd_data.
    tag_vld_d[0] = (state_d == FETCH) && in_img;
    tag_idx_d[0] = cur_idx_d;
    for (int k = 1; k <= MEM_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1] && !abort_hit;
      tag_idx_d[k] = tag_idx_q[k-1];
    end

    pix_d = pix_q;
    if (load_cur && state_d == FETCH) begin
      for (int e = 0; e < NPOS; e++) pix_d[e] = 8'h00;
    end
    if (tag_vld_q[MEM_LAT] && !abort_hit) pix_d[tag_idx_q[MEM_LAT]] = rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_cont_q   <= 1'b0;
      tile_x_q      <= '0;
      tile_y_q      <= '0;
      col0_q        <= '0;
      row0_q        <= '0;
      rowbase_q     <= '0;
      cur_c_q       <= '0;
      cur_idx_q     <= '0;
      cur_row_q     <= '0;
      cur_col_q     <= '0;
      cur_rowaddr_q <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_en_q       <= 1'b0;
      for (int k = 0; k <= MEM_LAT; k++) begin
        tag_vld_q[k] <= 1'b0;
        tag_idx_q[k] <= '0;
      end
      for (int e = 0; e < NPOS; e++) pix_q[e] <= 8'h00;
    end else begin
      state_q       <= state_d;
      mode_cont_q   <= mode_cont_d;
      tile_x_q      <= tile_x_d;
      tile_y_q      <= tile_y_d;
      col0_q        <= col0_d;
      row0_q        <= row0_d;
      rowbase_q     <= rowbase_d;
      cur_c_q       <= cur_c_d;
      cur_idx_q     <= cur_idx_d;
      cur_row_q     <= cur_row_d;
      cur_col_q     <= cur_col_d;
      cur_rowaddr_q <= cur_rowaddr_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
      for (int k = 0; k <= MEM_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_d[k];
        tag_idx_q[k] <= tag_idx_d[k];
      end
      for (int e = 0; e < NPOS; e++) pix_q[e] <= pix_d[e];
    end
  end

  for (genvar e = 0; e < NPOS; e++) begin : g_npu_in
    assign npu_in[e*16 +: 16] = {8'h00, pix_q[e]};
  end

  assign rd_addr   = rd_addr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign npu_start = (state_q == RUN);
  assign busy      = (state_q != IDLE) && (state_q != FINISH);
  assign paused    = (state_q == PAUSE);
  assign done      = (state_q == FINISH);
  assign tile_x    = tile_x_q;
  assign tile_y    = tile_y_q;

endmodule

// File: tb/tb_npu_tile_sequencer.sv
// Bench for npu_tile_sequencer on a 25x15 image, 10x10 tiles, 3-cycle source
// latency, with an echoing NPU model and a destination write monitor.
module tb_npu_tile_sequencer;

  localparam int IW   = 25;
  localparam int IH   = 15;
  localparam int T    = 10;
  localparam int AW   = 19;
  localparam int ML   = 3;
  localparam int NPIX = IW * IH;
  localparam int NE   = T * T;

  logic              clk = 1'b0;
  logic              rst, start_pulse, step_pulse, abort, force_done;
  logic [AW-1:0]     rd_addr, wr_addr;
  logic [7:0]        rd_data, wr_data, tile_x, tile_y;
  logic [NE*16-1:0]  npu_in;
  logic [NE*8-1:0]   npu_out = '0;
  logic              npu_start, npu_done, npu_done_m = 1'b0;
  logic              wr_en, busy, paused, done;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt, wr_oob, done_cnt, pause_entries;
  int npu_cnt = 0;
  logic paused_prev = 1'b0;
  logic [7:0] dst [NPIX];
  logic [7:0] rd_pipe [ML];

  npu_tile_sequencer #(.IMG_W(IW), .IMG_H(IH), .TILE(T), .ADDR_W(AW), .MEM_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .step_pulse(step_pulse),
    .abort(abort), .rd_addr(rd_addr), .rd_data(rd_data), .npu_in(npu_in),
    .npu_start(npu_start), .npu_done(npu_done), .npu_out(npu_out),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en), .busy(busy),
    .paused(paused), .done(done), .tile_x(tile_x), .tile_y(tile_y)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_byte(int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [7:0] exp_elem(int tx, int ty, int e);
    int row, col;
    row = ty * T + e / T;
    col = tx * T + e % T;
    if (row < IH && col < IW) return src_byte(row * IW + col);
    return 8'h00;
  endfunction

  // Source memory with three registered stages of read latency.
  always @(posedge clk) begin
    rd_pipe[0] <= (rd_addr < AW'(NPIX)) ? src_byte(int'(rd_addr)) : 8'h00;
    for (int k = 1; k < ML; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign rd_data = rd_pipe[ML-1];

  // NPU model: echoes the low byte of each element a few cycles after start.
  always @(posedge clk) begin
    npu_done_m <= (npu_cnt == 1);
    if (npu_start) begin
      npu_cnt <= 5;
      for (int e = 0; e < NE; e++) npu_out[e*8 +: 8] <= npu_in[e*16 +: 8];
    end else if (npu_cnt != 0) begin
      npu_cnt <= npu_cnt - 1;
    end
  end
  assign npu_done = npu_done_m | force_done;

  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt++;
      if (int'(wr_addr) >= NPIX) wr_oob++;
      else dst[wr_addr] = wr_data;
    end
    if (done) done_cnt++;
    if (paused && !paused_prev) pause_entries++;
    paused_prev = paused;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_run();
    wr_cnt = 0; wr_oob = 0; done_cnt = 0; pause_entries = 0;
    for (int i = 0; i < NPIX; i++) dst[i] = ~src_byte(i);
  endtask

  function automatic int dst_bad();
    int b = 0;
    for (int i = 0; i < NPIX; i++) if (dst[i] !== src_byte(i)) b++;
    return b;
  endfunction

  task automatic wait_for(input int which, input int maxc, input string name);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < maxc && !hit; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = npu_start;
        1:       hit = done;
        2:       hit = paused;
        default: hit = wr_en && (wr_addr == AW'(92));
      endcase
    end
    check({"reached ", name}, hit, 1);
  endtask

  typedef struct { int tx; int ty; int e00; } tile_vec_t;
  tile_vec_t tv [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad;
    bit found;
    tv[0] = '{0, 0, 3};   tv[1] = '{1, 0, 73};  tv[2] = '{2, 0, 143};
    tv[3] = '{0, 1, 217}; tv[4] = '{1, 1, 31};  tv[5] = '{2, 1, 101};

    rst = 1'b1; start_pulse = 1'b0; step_pulse = 1'b0; abort = 1'b0; force_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst rd_addr", rd_addr, 0);
    check("rst wr_addr", wr_addr, 0);
    check("rst wr_data", wr_data, 0);
    check("rst wr_en", wr_en, 0);
    check("rst npu_start", npu_start, 0);
    check("rst busy", busy, 0);
    check("rst paused", paused, 0);
    check("rst done", done, 0);
    check("rst tile_x", tile_x, 0);
    check("rst tile_y", tile_y, 0);
    check("rst npu_in zero", (npu_in == '0), 1);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 0);

    // Continuous run started by simultaneous start+step.
    clear_run();
    start_pulse = 1'b1; step_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0; step_pulse = 1'b0;
    check("busy after accept", busy, 1);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("first rd_addr[%0d]", i), rd_addr, (i < 10) ? i : IW);
    end
    cyc = 10; found = 1'b0;
    while (cyc < 400 && !found) begin
      @(negedge clk);
      cyc++;
      force_done = (cyc == 50);
      if (npu_start) found = 1'b1;
    end
    force_done = 1'b0;
    check("npu_start cycle (fetch+drain)", cyc, 103);

    for (int k = 0; k < 6; k++) begin
      if (k > 0) wait_for(0, 1000, $sformatf("npu_start tile %0d", k));
      check($sformatf("tile %0d tile_x", k), tile_x, tv[k].tx);
      check($sformatf("tile %0d tile_y", k), tile_y, tv[k].ty);
      check($sformatf("tile %0d elem00", k), npu_in[15:0], tv[k].e00);
      bad = 0;
      for (int e = 0; e < NE; e++)
        if (npu_in[e*16 +: 16] !== {8'h00, exp_elem(tv[k].tx, tv[k].ty, e)}) bad++;
      check($sformatf("tile %0d npu_in bad elems", k), bad, 0);
      @(negedge clk);
      check($sformatf("tile %0d npu_start width", k), npu_start, 0);
      if (k == 0) begin
        step_pulse = 1'b1;
        @(negedge clk);
        step_pulse = 1'b0; start_pulse = 1'b1;
        @(negedge clk);
        start_pulse = 1'b0;
      end
    end
    wait_for(1, 2000, "done continuous");
    check("busy at done", busy, 0);
    repeat (5) @(negedge clk);
    check("cont done count", done_cnt, 1);
    check("cont write count", wr_cnt, NPIX);
    check("cont out-of-range writes", wr_oob, 0);
    check("cont dst mismatches", dst_bad(), 0);
    check("cont pause entries", pause_entries, 0);
    check("cont busy after", busy, 0);

    // Step mode, then switch to continuous from PAUSE.
    clear_run();
    step_pulse = 1'b1;
    @(negedge clk);
    step_pulse = 1'b0;
    wait_for(2, 1000, "pause 1");
    check("step1 writes", wr_cnt, 100);
    check("step1 tile_x", tile_x, 1);
    check("step1 tile_y", tile_y, 0);
    check("step1 busy", busy, 1);
    repeat (20) @(negedge clk);
    check("step1 still paused", paused, 1);
    check("step1 writes held", wr_cnt, 100);
    step_pulse = 1'b1;
    @(negedge clk);
    step_pulse = 1'b0;
    check("step2 left pause", paused, 0);
    wait_for(2, 1000, "pause 2");
    check("step2 writes", wr_cnt, 200);
    check("step2 tile_x", tile_x, 2);
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    wait_for(1, 3000, "done step");
    repeat (5) @(negedge clk);
    check("step write count", wr_cnt, NPIX);
    check("step dst mismatches", dst_bad(), 0);
    check("step done count", done_cnt, 1);
    check("step pause entries", pause_entries, 2);
    check("step paused after", paused, 0);
    check("step busy after", busy, 0);

    // Abort during WRITE of tile (1,0), element 37.
    clear_run();
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    wait_for(4, 2000, "write elem 37");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort wr_en", wr_en, 0);
    check("abort busy", busy, 0);
    check("abort paused", paused, 0);
    check("abort npu_start", npu_start, 0);
    check("abort writes", wr_cnt, 138);
    check("abort tile_x kept", tile_x, 1);
    repeat (300) @(negedge clk);
    check("abort no done", done_cnt, 0);
    check("abort no more writes", wr_cnt, 138);
    clear_run();
    start_pulse = 1'b1;
    @(negedge clk);
    start_pulse = 1'b0;
    check("restart tile_x", tile_x, 0);
    check("restart tile_y", tile_y, 0);
    check("restart rd_addr", rd_addr, 0);
    check("restart busy", busy, 1);
    wait_for(1, 3000, "done restart");
    repeat (5) @(negedge clk);
    check("restart write count", wr_cnt, NPIX);
    check("restart dst mismatches", dst_bad(), 0);
    check("restart done count", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/npu_tile_sequencer.md
Name: npu_tile_sequencer

Overview:
- Parametrised tile scheduler that walks an IMG_W x IMG_H 8-bit image in TILE x TILE blocks.
- For each tile it fetches pixels from the source memory (ROM port), packs them into the NPU input bus and pulses the NPU.
- It then writes the NPU result tile to the destination memory (RAM port).
- Next-generation sequencer: supports arbitrary image/tile sizes with edge padding, configurable memory read latency, step/continuous modes and abort.

Parameters:
IMG_W, 400, image width in pixels (>= 1)
IMG_H, 400, image height in pixels (>= 1)
TILE, 10, tile edge length (2..16)
ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
MEM_LAT, 1, source read latency in cycles (1..4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start_pulse  in  1  one-cycle pulse, already debounced: run continuously
step_pulse  in  1  one-cycle pulse, already debounced: process one tile, then pause
abort  in  1  level: cancel current job
rd_addr  out  ADDR_W  source read address
rd_data  in  8  source data, valid MEM_LAT cycles after rd_addr is issued
npu_in  out  TILE*TILE*16  input tile; element (r,c) at bits [(r*TILE+c)*16 +: 16], zero-extended
npu_start  out  1  one-cycle NPU start pulse
npu_done  in  1  NPU completion pulse
npu_out  in  TILE*TILE*8  result tile, same element ordering, 8 bits each
wr_addr  out  ADDR_W  destination address
wr_data  out  8  destination data
wr_en  out  1  destination write strobe
busy  out  1  high from job accept until done or abort
paused  out  1  high while waiting in PAUSE
done  out  1  one-cycle pulse when the last tile has been written
tile_x  out  8  current tile column index
tile_y  out  8  current tile row index

Behaviour:
- Reset values: rd_addr=0, npu_in=0, npu_start=0, wr_addr=0, wr_data=0, wr_en=0, busy=0, paused=0, done=0, tile_x=0, tile_y=0, state=IDLE.
- Tile grid: NX = ceil(IMG_W/TILE), NY = ceil(IMG_H/TILE). Order is raster, tile_x fastest.
- Pixel address: (tile_y*TILE+r)*IMG_W + tile_x*TILE + c. Generate it with incremental counters; no runtime multipliers.
- States: IDLE, FETCH, DRAIN, RUN, WAIT_NPU, WRITE, ADVANCE, PAUSE, FINISH.
- IDLE:
  - start_pulse: mode=continuous.
  - step_pulse: mode=step.
  - Either pulse sets tile 0,0, busy=1, next FETCH.
  - start_pulse and step_pulse in the same cycle: start wins.
- FETCH:
  - Visits the TILE*TILE positions in row-major order, one per cycle, with rd_addr registered.
  - A valid-tag shift register of depth MEM_LAT captures rd_data into npu_in element (r,c) exactly MEM_LAT cycles after issue.
  - Out-of-image positions (col >= IMG_W or row >= IMG_H) issue no capture; their element is forced to 0.
  - After the last position, go to DRAIN.
- DRAIN: wait until the shift register is empty, then go to RUN.
- RUN: assert npu_start for exactly one cycle, then go to WAIT_NPU.
- WAIT_NPU:
  - On npu_done, go to WRITE.
  - npu_done seen in any other state is ignored.
- WRITE:
  - One element per cycle, row-major, with wr_en/wr_addr/wr_data registered.
  - wr_en=0 for out-of-image positions.
  - After TILE*TILE cycles, go to ADVANCE.
- ADVANCE:
  - Last tile (NX-1, NY-1): go to FINISH.
  - Otherwise increment tile_x, wrapping to 0 and incrementing tile_y.
  - Then go to FETCH if continuous, or PAUSE if step.
- PAUSE:
  - paused=1.
  - step_pulse: go to FETCH.
  - start_pulse: mode=continuous, go to FETCH. start wins if both pulses arrive together.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- start_pulse and step_pulse are ignored in every state other than IDLE and PAUSE.
- abort (any state except IDLE):
  - Next cycle: state=IDLE, busy=0, paused=0, wr_en=0, npu_start=0, pending captures discarded.
  - done is not pulsed. tile_x and tile_y keep their values.
- Per-tile cycle count: TILE² (FETCH) + MEM_LAT (DRAIN) + 1 (RUN) + NPU latency + TILE² (WRITE) + 1 (ADVANCE).
- npu_in is held stable from RUN until the next FETCH begins.

Test Plan:
- Tile grid, continuous: IMG_W=IMG_H=20, TILE=10, MEM_LAT=1, model NPU echoes low 8 bits after 5 cycles, start_pulse -> tiles (0,0),(1,0),(0,1),(1,1); 400 writes, destination == source; single done pulse; first tile's first rd_addr values 0,1,..,9,20.
- Edge padding: IMG_W=25, IMG_H=15, TILE=10 -> 6 tiles. Tile (2,1) npu_in element (0,0)=src[10*25+20]; elements with c>=5 or r>=5 are 0. Exactly 375 writes total, none to addresses >= 375.
- Step mode: step_pulse -> one tile written, paused=1, tile_x=1. Second step_pulse -> second tile. start_pulse in PAUSE -> remaining tiles run continuously, then done.
- Read latency: MEM_LAT=3 with a 3-stage source model -> npu_in matches source exactly; DRAIN lasts 3 cycles.
- Abort mid-WRITE at element 37 -> wr_en low the next cycle, busy=0, no done pulse. Fresh start_pulse restarts at tile 0,0.
- Simultaneous start_pulse+step_pulse in IDLE -> continuous run. Pulses during WAIT_NPU -> no effect. Spurious npu_done in FETCH -> ignored.
